// File: rtl/jellyvl_etherneco_packet_pkg.sv
// Shared definitions for the etherneco packet stages (TX and RX).
//   state_t       : parser/generator states, one-hot encoded
//   PREAMBLE_BYTE : preamble filler byte
//   SFD_BYTE      : start-of-frame delimiter
//   FCS_BYTES     : number of FCS bytes trailing the payload
package jellyvl_etherneco_packet_pkg;

    localparam int         BYTE_WIDTH    = 8;
    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;
    localparam int         FCS_BYTES     = 4;

    typedef enum logic [7:0] {
        IDLE     = 8'b0000_0001,
        PREAMBLE = 8'b0000_0010,
        LENGTH   = 8'b0000_0100,
        TYPE     = 8'b0000_1000,
        NODE     = 8'b0001_0000,
        PAYLOAD  = 8'b0010_0000,
        FCS      = 8'b0100_0000,
        ERROR    = 8'b1000_0000
    } state_t;

endpackage

// File: rtl/jellyvl_etherneco_packet_rx_if.sv
// Byte-stream bundle used for both the framed RX input and the payload output.
//   first : first byte of the stream unit
//   last  : last byte of the stream unit
//   data  : byte
//   valid : byte strobe (no back-pressure)
// master drives the stream, slave receives it.
interface jellyvl_etherneco_packet_rx_if;
    import jellyvl_etherneco_packet_pkg::*;

    logic                  first;
    logic                  last;
    logic [BYTE_WIDTH-1:0] data;
    logic                  valid;

    modport master (output first, output last, output data, output valid);
    modport slave  (input  first, input  last, input  data, input  valid);
endinterface

// File: rtl/jelly2_calc_crc.sv
// Byte-serial CRC engine with a registered result.
//   reset     : synchronous, active high; loads all ones
//   clk, cke  : clock and clock enable
//   in_update : 0 restarts from the all-ones seed with this word, 1 continues
//   in_data   : data word, processed MSB first (LSB first when REVERSED)
//   in_valid  : word strobe
//   out_crc   : CRC over all words since the last restart (no final XOR)
module jelly2_calc_crc #(
    parameter int                   DATA_WIDTH = 8,
    parameter int                   CRC_WIDTH  = 32,
    parameter logic [CRC_WIDTH-1:0] POLY_REPS  = 32'h04C11DB7,
    parameter bit                   REVERSED   = 1'b0
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  cke,
    input  logic                  in_update,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [CRC_WIDTH-1:0]  out_crc
);

    logic [CRC_WIDTH-1:0] crc_reg;
    logic [CRC_WIDTH-1:0] poly_refl;

    // bit-mirrored polynomial for the reflected form
    genvar gi;
    generate
        for (gi = 0; gi < CRC_WIDTH; gi++) begin : g_refl
            assign poly_refl[gi] = POLY_REPS[CRC_WIDTH-1-gi];
        end
    endgenerate

    function automatic logic [CRC_WIDTH-1:0] crc_step(
        input logic [CRC_WIDTH-1:0]  crc,
        input logic [DATA_WIDTH-1:0] data
    );
        logic [CRC_WIDTH-1:0] c;
        logic                 fb;
        c = crc;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (REVERSED) begin
                fb = c[0] ^ data[i];
                c  = c >> 1;
                if (fb) c = c ^ poly_refl;
            end else begin
                fb = c[CRC_WIDTH-1] ^ data[DATA_WIDTH-1-i];
                c  = c << 1;
                if (fb) c = c ^ POLY_REPS;
            end
        end
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            crc_reg <= '1;
        end else if (cke && in_valid) begin
            crc_reg <= crc_step(in_update ? crc_reg : '1, in_data);
        end
    end

    assign out_crc = crc_reg;

endmodule

// File: rtl/jellyvl_etherneco_packet_rx.sv
// Receive-side parser for the etherneco framed byte stream.
// Frame: 0x55 x1..PREAMBLE_MAX, 0xD5, LENGTH(2, LSB first, = payload-1),
//        TYPE, NODE, PAYLOAD(LENGTH+1), FCS(4, LSB first, CRC-32 over LENGTH..PAYLOAD).
//   clk, reset_n       : clock, synchronous active-low reset
//   s_rx               : framed input bytes (slave, cannot be stalled)
//   m_header_valid     : pulse, m_length/m_type/m_node updated
//   m_payload          : payload bytes (master), first/last mark the payload bounds
//   m_done             : pulse, frame finished; m_crc_ok / m_error qualify it
// All outputs are registered one cycle after the accepted byte.
module jellyvl_etherneco_packet_rx
    import jellyvl_etherneco_packet_pkg::*;
#(
    parameter int          PREAMBLE_MAX = 7,
    parameter logic [31:0] CRC_POLY     = 32'h04C11DB7
) (
    input  logic                                clk,
    input  logic                                reset_n,
    jellyvl_etherneco_packet_rx_if.slave        s_rx,
    output logic                                m_header_valid,
    output logic [15:0]                         m_length,
    output logic [7:0]                          m_type,
    output logic [7:0]                          m_node,
    jellyvl_etherneco_packet_rx_if.master       m_payload,
    output logic                                m_done,
    output logic                                m_crc_ok,
    output logic                                m_error
);

    localparam int                CNT_W   = $clog2(PREAMBLE_MAX + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(PREAMBLE_MAX);

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               len_hi_reg;
    logic [15:0]        len_reg;
    logic [7:0]         type_reg;
    logic [15:0]        rem_reg;
    logic [1:0]         fcs_cnt_reg;
    logic [23:0]        fcs_shift_reg;
    // set when the frame's m_done was already issued on entry to ERROR,
    // so the closing s_rx_last does not report the same frame twice
    logic               err_reported_reg;

    logic               pay_first_reg;
    logic               pay_last_reg;
    logic [7:0]         pay_data_reg;
    logic               pay_valid_reg;

    logic               crc_update;
    logic               crc_valid;
    logic [31:0]        crc_value;
    logic               early_last;

    // CRC covers LENGTH..PAYLOAD; first LENGTH byte reseeds it, FCS leaves it frozen
    always_comb begin
        crc_valid  = 1'b0;
        crc_update = 1'b1;
        if (s_rx.valid && !s_rx.first) begin
            case (state_reg)
                LENGTH: begin
                    crc_valid  = 1'b1;
                    crc_update = len_hi_reg;
                end
                TYPE, NODE, PAYLOAD: crc_valid = 1'b1;
                default: ;
            endcase
        end
    end

    jelly2_calc_crc #(
        .DATA_WIDTH (8),
        .CRC_WIDTH  (32),
        .POLY_REPS  (CRC_POLY),
        .REVERSED   (1'b0)
    ) u_calc_crc (
        .reset      (!reset_n),
        .clk        (clk),
        .cke        (1'b1),
        .in_update  (crc_update),
        .in_data    (s_rx.data),
        .in_valid   (crc_valid),
        .out_crc    (crc_value)
    );

    // s_rx_last anywhere short of the 4th FCS byte is an abort
    assign early_last = s_rx.last && !(state_reg == FCS && fcs_cnt_reg == 2'd3);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg        <= IDLE;
            cnt_reg          <= '0;
            len_hi_reg       <= 1'b0;
            len_reg          <= '0;
            type_reg         <= '0;
            rem_reg          <= '0;
            fcs_cnt_reg      <= '0;
            fcs_shift_reg    <= '0;
            err_reported_reg <= 1'b0;
            pay_first_reg    <= 1'b0;
            pay_last_reg     <= 1'b0;
            pay_data_reg     <= '0;
            pay_valid_reg    <= 1'b0;
            m_header_valid   <= 1'b0;
            m_length         <= '0;
            m_type           <= '0;
            m_node           <= '0;
            m_done           <= 1'b0;
            m_crc_ok         <= 1'b0;
            m_error          <= 1'b0;
        end else begin
            m_header_valid <= 1'b0;
            pay_valid_reg  <= 1'b0;
            pay_first_reg  <= 1'b0;
            pay_last_reg   <= 1'b0;
            m_done         <= 1'b0;
            m_crc_ok       <= 1'b0;
            m_error        <= 1'b0;

            if (s_rx.valid) begin
                if (s_rx.first && state_reg != IDLE) begin
                    // close the running frame and reuse this byte as a new start
                    if (!(state_reg == ERROR && err_reported_reg)) begin
                        m_done  <= 1'b1;
                        m_error <= 1'b1;
                    end
                    err_reported_reg <= 1'b0;
                    if (s_rx.data == PREAMBLE_BYTE && !s_rx.last) begin
                        state_reg <= PREAMBLE;
                        cnt_reg   <= CNT_W'(1);
                    end else begin
                        state_reg <= IDLE;
                    end
                end else if (state_reg == IDLE) begin
                    if (s_rx.first && s_rx.data == PREAMBLE_BYTE && !s_rx.last) begin
                        state_reg <= PREAMBLE;
                        cnt_reg   <= CNT_W'(1);
                    end
                end else if (state_reg == ERROR) begin
                    if (s_rx.last) begin
                        if (!err_reported_reg) begin
                            m_done  <= 1'b1;
                            m_error <= 1'b1;
                        end
                        err_reported_reg <= 1'b0;
                        state_reg        <= IDLE;
                    end
                end else if (early_last) begin
                    m_done    <= 1'b1;
                    m_error   <= 1'b1;
                    state_reg <= IDLE;
                end else begin
                    case (state_reg)
                        PREAMBLE: begin
                            if (s_rx.data == PREAMBLE_BYTE && cnt_reg < CNT_MAX) begin
                                cnt_reg <= cnt_reg + CNT_W'(1);
                            end else if (s_rx.data == SFD_BYTE) begin
                                len_hi_reg <= 1'b0;
                                state_reg  <= LENGTH;
                            end else begin
                                state_reg <= ERROR;
                            end
                        end
                        LENGTH: begin
                            if (!len_hi_reg) begin
                                len_reg[7:0] <= s_rx.data;
                                len_hi_reg   <= 1'b1;
                            end else begin
                                len_reg[15:8] <= s_rx.data;
                                state_reg     <= TYPE;
                            end
                        end
                        TYPE: begin
                            type_reg  <= s_rx.data;
                            state_reg <= NODE;
                        end
                        NODE: begin
                            m_length       <= len_reg;
                            m_type         <= type_reg;
                            m_node         <= s_rx.data;
                            m_header_valid <= 1'b1;
                            rem_reg        <= len_reg;
                            state_reg      <= PAYLOAD;
                        end
                        PAYLOAD: begin
                            pay_valid_reg <= 1'b1;
                            pay_data_reg  <= s_rx.data;
                            pay_first_reg <= (rem_reg == len_reg);
                            pay_last_reg  <= (rem_reg == 16'd0);
                            if (rem_reg == 16'd0) begin
                                fcs_cnt_reg <= 2'd0;
                                state_reg   <= FCS;
                            end else begin
                                rem_reg <= rem_reg - 16'd1;
                            end
                        end
                        FCS: begin
                            fcs_shift_reg <= {s_rx.data, fcs_shift_reg[23:8]};
                            fcs_cnt_reg   <= fcs_cnt_reg + 2'd1;
                            if (fcs_cnt_reg == 2'd3) begin
                                m_done <= 1'b1;
                                if (s_rx.last) begin
                                    m_crc_ok  <= ({s_rx.data, fcs_shift_reg} == crc_value);
                                    state_reg <= IDLE;
                                end else begin
                                    m_error          <= 1'b1;
                                    err_reported_reg <= 1'b1;
                                    state_reg        <= ERROR;
                                end
                            end
                        end
                        default: state_reg <= IDLE;
                    endcase
                end
            end
        end
    end

    assign m_payload.first = pay_first_reg;
    assign m_payload.last  = pay_last_reg;
    assign m_payload.data  = pay_data_reg;
    assign m_payload.valid = pay_valid_reg;

endmodule

// File: tb/tb_jellyvl_etherneco_packet_rx.sv
// Directed bench for jellyvl_etherneco_packet_rx: builds frames with a
// reference CRC-32 (poly 04C11DB7, seed all ones, MSB first, no final XOR),
// feeds them and checks the captured header / payload / done reports.
module tb_jellyvl_etherneco_packet_rx;

    logic        clk;
    logic        reset_n;
    logic        m_header_valid;
    logic [15:0] m_length;
    logic [7:0]  m_type;
    logic [7:0]  m_node;
    logic        m_done;
    logic        m_crc_ok;
    logic        m_error;

    jellyvl_etherneco_packet_rx_if rx_if ();
    jellyvl_etherneco_packet_rx_if pay_if ();

    jellyvl_etherneco_packet_rx #(
        .PREAMBLE_MAX (7),
        .CRC_POLY     (32'h04C11DB7)
    ) u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .s_rx           (rx_if),
        .m_header_valid (m_header_valid),
        .m_length       (m_length),
        .m_type         (m_type),
        .m_node         (m_node),
        .m_payload      (pay_if),
        .m_done         (m_done),
        .m_crc_ok       (m_crc_ok),
        .m_error        (m_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // capture of DUT activity, sampled on the falling edge
    logic [7:0] pay_q[$];
    logic       done_ok_q[$];
    logic       done_err_q[$];
    int hdr_cnt, first_cnt, last_cnt, first_pos, last_pos;

    always @(negedge clk) begin
        if (m_header_valid) begin
            hdr_cnt++;
            $display("header len=%04h type=%02h node=%02h", m_length, m_type, m_node);
        end
        if (pay_if.valid) begin
            if (pay_if.first) begin first_cnt++; first_pos = pay_q.size(); end
            if (pay_if.last)  begin last_cnt++;  last_pos  = pay_q.size(); end
            pay_q.push_back(pay_if.data);
        end
        if (m_done) begin
            done_ok_q.push_back(m_crc_ok);
            done_err_q.push_back(m_error);
            $display("frame done crc_ok=%0d error=%0d payload_bytes=%0d", m_crc_ok, m_error, pay_q.size());
        end
    end

    task automatic clear_mon();
        pay_q.delete();
        done_ok_q.delete();
        done_err_q.delete();
        hdr_cnt = 0; first_cnt = 0; last_cnt = 0; first_pos = -1; last_pos = -1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    logic [7:0] frame_q[$];
    int         pay_start;

    // payload byte i = base + i
    task automatic build_frame(input int npre, input logic [15:0] len, input logic [7:0] typ,
                               input logic [7:0] node, input logic [7:0] base);
        logic [31:0] crc;
        logic [7:0]  b;
        logic [7:0]  hdr[4];
        frame_q.delete();
        repeat (npre) frame_q.push_back(8'h55);
        frame_q.push_back(8'hD5);
        crc = 32'hFFFF_FFFF;
        hdr[0] = len[7:0]; hdr[1] = len[15:8]; hdr[2] = typ; hdr[3] = node;
        for (int i = 0; i < 4; i++) begin
            frame_q.push_back(hdr[i]);
            crc = crc_byte(crc, hdr[i]);
        end
        pay_start = frame_q.size();
        for (int i = 0; i <= int'(len); i++) begin
            b = base + 8'(i);
            frame_q.push_back(b);
            crc = crc_byte(crc, b);
        end
        for (int i = 0; i < 4; i++) frame_q.push_back(crc[8*i +: 8]);
    endtask

    task automatic put(input logic [7:0] d, input logic f, input logic l);
        rx_if.valid = 1'b1; rx_if.data = d; rx_if.first = f; rx_if.last = l;
        @(posedge clk); #1;
        rx_if.valid = 1'b0; rx_if.first = 1'b0; rx_if.last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // send the first 'upto' bytes; last flag only when the whole frame is sent
    task automatic send_frame(input int upto, input bit gaps);
        for (int i = 0; i < upto; i++) begin
            put(frame_q[i], i == 0, i == frame_q.size() - 1);
            if (gaps) idle($urandom_range(0, 2));
        end
    endtask

    task automatic check_frame(input string t, input logic [31:0] exp_pay, input logic exp_ok);
        check({t, ".hdr_cnt"},   hdr_cnt, 1);
        check({t, ".length"},    m_length, 16'd3);
        check({t, ".type"},      m_type, 8'h12);
        check({t, ".node"},      m_node, 8'h05);
        check({t, ".pay_cnt"},   pay_q.size(), 4);
        check({t, ".pay_data"},  {pay_q[0], pay_q[1], pay_q[2], pay_q[3]}, exp_pay);
        check({t, ".first_pos"}, first_pos, 0);
        check({t, ".last_pos"},  last_pos, 3);
        check({t, ".first_cnt"}, first_cnt + last_cnt, 2);
        check({t, ".done_cnt"},  done_ok_q.size(), 1);
        check({t, ".crc_ok"},    done_ok_q[0], exp_ok);
        check({t, ".error"},     done_err_q[0], 1'b0);
    endtask

    initial begin
        logic [7:0] ref_str[9];
        logic [31:0] ref_crc;
        int bad;

        rx_if.valid = 1'b0; rx_if.first = 1'b0; rx_if.last = 1'b0; rx_if.data = 8'h00;
        reset_n = 1'b0;
        clear_mon();

        // reference model sanity: CRC-32/MPEG-2 check value of "123456789"
        ref_crc = 32'hFFFF_FFFF;
        for (int i = 0; i < 9; i++) begin
            ref_str[i] = 8'h31 + 8'(i);
            ref_crc = crc_byte(ref_crc, ref_str[i]);
        end
        check("model.crc_check", ref_crc, 32'h0376E6E7);

        repeat (3) @(posedge clk);
        #1;
        check("reset.length",   m_length, 16'h0000);
        check("reset.type",     m_type, 8'h00);
        check("reset.node",     m_node, 8'h00);
        check("reset.pulses",   {m_header_valid, pay_if.valid, m_done, m_crc_ok, m_error}, 5'b0);
        reset_n = 1'b1;
        idle(2);

        // 1: good frame, 7 preamble bytes (boundary)
        clear_mon();
        build_frame(7, 16'd3, 8'h12, 8'h05, 8'h01);
        send_frame(frame_q.size(), 1'b0);
        idle(3);
        check_frame("t1", 32'h01020304, 1'b1);

        // 2: one payload bit flipped in flight
        clear_mon();
        build_frame(1, 16'd3, 8'h12, 8'h05, 8'h01);
        frame_q[pay_start + 1] = frame_q[pay_start + 1] ^ 8'h04;
        send_frame(frame_q.size(), 1'b0);
        idle(3);
        check_frame("t2", 32'h01060304, 1'b0);

        // 3: same frame as 1 with random valid gaps
        clear_mon();
        build_frame(7, 16'd3, 8'h12, 8'h05, 8'h01);
        send_frame(frame_q.size(), 1'b1);
        idle(3);
        check_frame("t3", 32'h01020304, 1'b1);

        // 4: abort byte after 2nd payload byte
        clear_mon();
        build_frame(3, 16'd3, 8'h12, 8'h05, 8'h01);
        send_frame(pay_start + 2, 1'b0);
        put(8'h00, 1'b0, 1'b1);
        idle(3);
        check("t4.pay_cnt",  pay_q.size(), 2);
        check("t4.last_cnt", last_cnt, 0);
        check("t4.done_cnt", done_ok_q.size(), 1);
        check("t4.error",    done_err_q[0], 1'b1);
        check("t4.crc_ok",   done_ok_q[0], 1'b0);

        // 5: new frame start during PAYLOAD, then a good frame
        clear_mon();
        build_frame(2, 16'd3, 8'h12, 8'h05, 8'h01);
        send_frame(pay_start + 2, 1'b0);
        send_frame(frame_q.size(), 1'b0);
        idle(3);
        check("t5.done_cnt", done_ok_q.size(), 2);
        check("t5.abort",    {done_err_q[0], done_ok_q[0]}, 2'b10);
        check("t5.good",     {done_err_q[1], done_ok_q[1]}, 2'b01);
        check("t5.hdr_cnt",  hdr_cnt, 2);
        check("t5.pay_cnt",  pay_q.size(), 6);

        // 7: eight preamble bytes exceed PREAMBLE_MAX
        clear_mon();
        build_frame(8, 16'd3, 8'h12, 8'h05, 8'h01);
        send_frame(frame_q.size(), 1'b0);
        idle(3);
        check("t7.hdr_cnt",  hdr_cnt, 0);
        check("t7.done",     {done_ok_q.size() == 1, done_err_q[0], done_ok_q[0]}, 3'b110);

        // 6: reset mid-PAYLOAD, then a 65536-byte frame
        clear_mon();
        build_frame(1, 16'd3, 8'h34, 8'h07, 8'h10);
        send_frame(pay_start + 2, 1'b0);
        reset_n = 1'b0;
        rx_if.valid = 1'b1; rx_if.data = 8'h12;
        @(posedge clk); #1;
        rx_if.valid = 1'b0;
        check("t6.rst_pulses", {m_header_valid, pay_if.valid, m_done, m_crc_ok, m_error}, 5'b0);
        check("t6.rst_length", m_length, 16'h0000);
        reset_n = 1'b1;
        idle(2);
        check("t6.no_done", done_ok_q.size(), 0);
        clear_mon();
        build_frame(1, 16'hFFFF, 8'hA5, 8'h3C, 8'h00);
        send_frame(frame_q.size(), 1'b0);
        idle(3);
        bad = 0;
        for (int i = 0; i < pay_q.size(); i++) if (pay_q[i] !== 8'(i)) bad++;
        check("t6.length",   m_length, 16'hFFFF);
        check("t6.type",     {m_type, m_node}, 16'hA53C);
        check("t6.pay_cnt",  pay_q.size(), 65536);
        check("t6.pay_bad",  bad, 0);
        check("t6.last_pos", last_pos, 65535);
        check("t6.done",     {done_ok_q.size() == 1, done_ok_q[0], done_err_q[0]}, 3'b110);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
